// File: rtl/sc_timebase_pkg.sv
// Shared run-control state encodings for the game-timer time base.
package sc_timebase_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSED  = 2'b10,
        STOPPED = 2'b11
    } tb_state_e;

endpackage

// File: rtl/sc_sync_fedge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low button.
// Event is one clock wide, two edges after the input falls; a held button gives a single event.
module sc_sync_fedge (
    input  logic SC_RegGENERAL_Time_CLOCK_50,
    input  logic SC_RegGENERAL_Time_RESET_InHigh,
    input  logic btn_in_low,
    output logic fedge_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = btn_in_low;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset to the released level so coming out of reset never looks like a press.
    always_ff @(posedge SC_RegGENERAL_Time_CLOCK_50 or posedge SC_RegGENERAL_Time_RESET_InHigh) begin
        if (SC_RegGENERAL_Time_RESET_InHigh) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign fedge_out = ~sync_q & hist_q;

endmodule

// File: rtl/sc_timebase_tickgen.sv
// Run-controlled prescaler emitting a one-clock active-low count-enable every TERMINAL+1 clocks.
// Buttons/stop act two edges after they change; tick lands the cycle after the prescaler wraps.
module sc_timebase_tickgen
    import sc_timebase_pkg::*;
#(
    parameter int PRESCALER_DATAWIDTH = 26,
    parameter int PRESCALER_TERMINAL  = 49999999
) (
    input  logic               SC_RegGENERAL_Time_CLOCK_50,
    input  logic               SC_RegGENERAL_Time_RESET_InHigh,
    input  logic               SC_TimeBase_start_InLow,
    input  logic               SC_TimeBase_pause_InLow,
    input  logic               SC_TimeBase_stop_InHigh,
    output logic               SC_TimeBase_upcount_OutLow,
    output logic               SC_TimeBase_running_OutHigh,
    output logic [STATE_W-1:0] SC_TimeBase_state_OutBUS
);

    localparam logic [PRESCALER_DATAWIDTH-1:0] TERM = PRESCALER_DATAWIDTH'(PRESCALER_TERMINAL);
    localparam logic [PRESCALER_DATAWIDTH-1:0] ONE  = PRESCALER_DATAWIDTH'(1);

    logic start_ev;
    logic pause_ev;

    sc_sync_fedge u_start_sync (
        .SC_RegGENERAL_Time_CLOCK_50     (SC_RegGENERAL_Time_CLOCK_50),
        .SC_RegGENERAL_Time_RESET_InHigh (SC_RegGENERAL_Time_RESET_InHigh),
        .btn_in_low                      (SC_TimeBase_start_InLow),
        .fedge_out                       (start_ev)
    );

    sc_sync_fedge u_pause_sync (
        .SC_RegGENERAL_Time_CLOCK_50     (SC_RegGENERAL_Time_CLOCK_50),
        .SC_RegGENERAL_Time_RESET_InHigh (SC_RegGENERAL_Time_RESET_InHigh),
        .btn_in_low                      (SC_TimeBase_pause_InLow),
        .fedge_out                       (pause_ev)
    );

    tb_state_e                      state_q, state_d;
    logic [PRESCALER_DATAWIDTH-1:0] presc_q, presc_d;
    logic                           stop_meta_q, stop_meta_d;
    logic                           stop_sync_q, stop_sync_d;
    logic                           upcount_q, upcount_d;
    logic                           running_q, running_d;
    logic                           tick_now;

    always_comb begin
        stop_meta_d = SC_TimeBase_stop_InHigh;
        stop_sync_d = stop_meta_q;
        state_d     = state_q;
        presc_d     = presc_q;
        tick_now    = 1'b0;

        // Priority: stop, then pause event, then start event.
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (stop_sync_q)   state_d = STOPPED;
                else if (start_ev) state_d = RUN;
            end
            RUN: begin
                if (stop_sync_q) begin
                    state_d = STOPPED;
                    presc_d = '0;
                end else if (pause_ev) begin
                    state_d = PAUSED;
                end else if (presc_q == TERM) begin
                    presc_d  = '0;
                    tick_now = 1'b1;
                end else begin
                    presc_d = presc_q + ONE;
                end
            end
            PAUSED: begin
                if (stop_sync_q) begin
                    state_d = STOPPED;
                    presc_d = '0;
                end else if (pause_ev || start_ev) begin
                    state_d = RUN;
                end
            end
            STOPPED: begin
                presc_d = '0;
                if (!stop_sync_q && start_ev) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase

        upcount_d = ~tick_now;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge SC_RegGENERAL_Time_CLOCK_50 or posedge SC_RegGENERAL_Time_RESET_InHigh) begin
        if (SC_RegGENERAL_Time_RESET_InHigh) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            stop_meta_q <= 1'b0;
            stop_sync_q <= 1'b0;
            upcount_q   <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            stop_meta_q <= stop_meta_d;
            stop_sync_q <= stop_sync_d;
            upcount_q   <= upcount_d;
            running_q   <= running_d;
        end
    end

    assign SC_TimeBase_upcount_OutLow  = upcount_q;
    assign SC_TimeBase_running_OutHigh = running_q;
    assign SC_TimeBase_state_OutBUS    = state_q;

endmodule

// File: tb/tb_sc_timebase_tickgen.sv
// Bench for sc_timebase_tickgen with TERMINAL=4: expected tick cycles are queued from stimulus timing.
module tb_sc_timebase_tickgen;
    import sc_timebase_pkg::*;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       pause_n;
    logic       stop;
    logic       upc;
    logic       running;
    logic [1:0] state_bus;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int tick_cnt = 0;
    bit mon_en = 0;
    int exp_q[$];

    sc_timebase_tickgen #(
        .PRESCALER_DATAWIDTH (26),
        .PRESCALER_TERMINAL  (4)
    ) dut (
        .SC_RegGENERAL_Time_CLOCK_50     (clk),
        .SC_RegGENERAL_Time_RESET_InHigh (rst),
        .SC_TimeBase_start_InLow         (start_n),
        .SC_TimeBase_pause_InLow         (pause_n),
        .SC_TimeBase_stop_InHigh         (stop),
        .SC_TimeBase_upcount_OutLow      (upc),
        .SC_TimeBase_running_OutHigh     (running),
        .SC_TimeBase_state_OutBUS        (state_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Every monitored cycle is compared: a tick exactly where queued, high everywhere else.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                void'(exp_q.pop_front());
                check_eq("tick", int'(upc), 0);
            end else begin
                check_eq("no_tick", int'(upc), 1);
            end
            if (!upc) begin
                tick_cnt++;
                check_eq("tick_in_run", int'(running), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, kr, kp, k1, k2, k3, k4, kr2, k5, k6, k7, kr3;
        rst = 1'b1; start_n = 1'b1; pause_n = 1'b1; stop = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", int'(state_bus), int'(IDLE));
        check_eq("rst_upcount", int'(upc), 1);
        check_eq("rst_running", int'(running), 0);
        rst = 1'b0;
        mon_en = 1;

        // Start from IDLE; first tick 5 clocks after RUN entry, then every 5.
        wait_to(2);
        k = cyc; kr = k + 3;
        start_n = 1'b0;
        for (int j = 1; j <= 7; j++) exp_q.push_back(kr + 5 * j);
        wait_to(k + 2); check_eq("start_latency", int'(state_bus), int'(IDLE));
        wait_to(k + 3); check_eq("run_entry", int'(state_bus), int'(RUN));
        check_eq("running_hi", int'(running), 1);
        start_n = 1'b1;
        wait_to(kr + 31);
        check_eq("tick_count_5_6", int'(tick_cnt >= 5 && tick_cnt <= 6), 1);

        // Pause with prescaler held at 2, then resume.
        wait_to(kr + 35);
        kp = cyc; pause_n = 1'b0;
        wait_to(kp + 3); check_eq("paused", int'(state_bus), int'(PAUSED));
        check_eq("paused_running", int'(running), 0);
        pause_n = 1'b1;
        wait_to(kp + 23); check_eq("still_paused", int'(state_bus), int'(PAUSED));
        k1 = cyc; pause_n = 1'b0;
        exp_q.push_back(k1 + 6);
        wait_to(k1 + 3); check_eq("resume", int'(state_bus), int'(RUN));
        pause_n = 1'b1;

        // Stop and pause together, landing on the wrap edge: stop wins, no tick.
        wait_to(k1 + 8);
        k2 = cyc; stop = 1'b1; pause_n = 1'b0;
        wait_to(k2 + 2); check_eq("stop_latency", int'(state_bus), int'(RUN));
        wait_to(k2 + 3); check_eq("stopped", int'(state_bus), int'(STOPPED));
        check_eq("stopped_running", int'(running), 0);
        pause_n = 1'b1;
        wait_to(k2 + 4); stop = 1'b0;
        wait_to(k2 + 10); check_eq("stopped_hold", int'(state_bus), int'(STOPPED));

        // Start held 50 clocks in STOPPED: one event only, so IDLE is kept.
        k3 = cyc; start_n = 1'b0;
        wait_to(k3 + 3); check_eq("stop_to_idle", int'(state_bus), int'(IDLE));
        wait_to(k3 + 50); check_eq("held_start_idle", int'(state_bus), int'(IDLE));
        start_n = 1'b1;

        // Start held 50 clocks from IDLE: one transition, undisturbed tick train.
        wait_to(k3 + 55);
        k4 = cyc; kr2 = k4 + 3; start_n = 1'b0;
        for (int j = 1; j <= 9; j++) exp_q.push_back(kr2 + 5 * j);
        wait_to(k4 + 3); check_eq("run_entry2", int'(state_bus), int'(RUN));
        wait_to(k4 + 50); check_eq("held_start_run", int'(state_bus), int'(RUN));
        start_n = 1'b1;

        // Pause on the prescaler=TERMINAL cycle: no tick; wraps on first RUN cycle after resume.
        k5 = cyc; pause_n = 1'b0;
        wait_to(k5 + 3); check_eq("paused_at_term", int'(state_bus), int'(PAUSED));
        pause_n = 1'b1;
        wait_to(k5 + 13);
        k6 = cyc; pause_n = 1'b0;
        exp_q.push_back(k6 + 4);
        exp_q.push_back(k6 + 9);
        wait_to(k6 + 3); check_eq("resume2", int'(state_bus), int'(RUN));
        pause_n = 1'b1;

        // Reset asserted while the tick is low clears outputs asynchronously.
        wait_to(k6 + 9);
        #2;
        rst = 1'b1;
        mon_en = 0;
        #1;
        check_eq("async_rst_upcount", int'(upc), 1);
        check_eq("async_rst_state", int'(state_bus), int'(IDLE));
        check_eq("async_rst_running", int'(running), 0);
        check_eq("queue_before_rst", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick_cnt = 0;
        mon_en = 1;

        // Restart after reset: period begins from 0 again.
        wait_to(2);
        k7 = cyc; kr3 = k7 + 3; start_n = 1'b0;
        exp_q.push_back(kr3 + 5);
        exp_q.push_back(kr3 + 10);
        wait_to(k7 + 3); check_eq("run_entry3", int'(state_bus), int'(RUN));
        start_n = 1'b1;
        wait_to(kr3 + 12);
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("restart_ticks", tick_cnt, 2);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sc_timebase_tickgen.md
# sc_timebase_tickgen

Time-base generator for the game timer. Divides SC_RegGENERAL_Time_CLOCK_50 into a periodic one-cycle active-low count-enable pulse that drives SC_upSPEEDCOUNTER_upcount_InLow of the downstream elapsed-time counter. A four-state run-control FSM provides start, pause/resume and game-over stop from player buttons and game logic, so the counter advances only while a race is running.

## Interface

- PRESCALER_DATAWIDTH, 26: prescaler counter width.
- PRESCALER_TERMINAL, 49999999: last prescaler value; tick period = TERMINAL+1 clocks (1 s at 50 MHz). Must fit in PRESCALER_DATAWIDTH.

- SC_RegGENERAL_Time_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- SC_RegGENERAL_Time_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_TimeBase_start_InLow  in  1  start button, asynchronous, active-low.
- SC_TimeBase_pause_InLow  in  1  pause/resume button, asynchronous, active-low.
- SC_TimeBase_stop_InHigh  in  1  game-over level, asynchronous, active-high.
- SC_TimeBase_upcount_OutLow  out  1  registered tick, low for exactly one clock per period.
- SC_TimeBase_running_OutHigh  out  1  registered, high while state = RUN.
- SC_TimeBase_state_OutBUS  out  2  registered FSM state code.

## Operation

- Input conditioning: start and pause each pass a 2-flop synchronizer (reset 1) plus history flop (reset 1); event = synced 0 and history 1 (falling edge), one clock wide. Holding a button yields one event. stop passes a 2-flop synchronizer (reset 0); level-sensitive.
- States: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10, STOPPED=2'b11.
- Priority per clock: stop > pause event > start event.
- IDLE: start event -> RUN, prescaler cleared to 0. Pause ignored. Stop -> STOPPED.
- RUN: stop -> STOPPED; pause event -> PAUSED; start event ignored.
- PAUSED: pause or start event -> RUN, prescaler resumes from held value; stop -> STOPPED.
- STOPPED: start event (with stop low) -> IDLE; otherwise hold.
- Prescaler: counts only in RUN and only when no stop/pause event that cycle; at PRESCALER_TERMINAL wraps to 0 and schedules a tick. Held in PAUSED, cleared in IDLE and STOPPED.
- Tick: upcount_OutLow registered; low in the cycle following the edge where the prescaler wraps, high otherwise. Never low outside RUN.
- Reset values: state IDLE, prescaler 0, upcount_OutLow 1, running_OutHigh 0, state_OutBUS 2'b00, all sync flops as above. Reset mid-pulse forces upcount_OutLow high immediately.

## Timing

- Button falling before rising edge E0: synced at E1, event during E1–E2, state updates at E2. Same 2-edge latency for stop.
- Tick period in RUN: exactly TERMINAL+1 clocks; first tick TERMINAL+1 clocks after entering RUN from IDLE.
- Pause coinciding with prescaler = TERMINAL: pause wins, no tick, prescaler holds TERMINAL; first RUN cycle after resume wraps and ticks next cycle.
- Stop coinciding with wrap: no tick.
- running_OutHigh and state_OutBUS change on the same edge as the state.

## Structure

- Package sc_timebase_pkg: state encodings (IDLE, RUN, PAUSED, STOPPED), state width constant 2.
- Sub-module sc_sync_fedge: 2-flop synchronizer plus falling-edge detector, instantiated for start and pause; stop uses its synchronizer output only.
- Top: FSM register, next-state logic, prescaler, registered outputs.

## Test plan

- TERMINAL=4: reset, start pulse, run 30 clocks -> state 01, upcount_OutLow low one clock every 5 clocks, first low 5 clocks after RUN entry; downstream counter reaches 5–6.
- Pause at prescaler=2, wait 20 clocks, pause again -> no ticks while state 10; next tick exactly 2 clocks after prescaler resumes counting.
- Hold start low 50 clocks -> single event, single IDLE->RUN transition.
- Assert stop and pause simultaneously in RUN -> state 11, running 0, no tick; start then -> state 00.
- Pause event on the prescaler=TERMINAL cycle -> no tick; after resume, tick one clock after first RUN cycle.
- Assert reset while upcount_OutLow low -> output 1, state 00 asynchronously; after release, start restarts period from 0.
